tetris_round_scheduler: RTL

Sequences piece requests into the Tetris engine (6-wide × 12-row board, 16-piece rounds, `in_valid`/`score_valid` handshake). Upstream piece requests are buffered in a small FIFO and issued to the engine one at a time; the next piece is issued only after the engine answers. The block tracks round boundaries (16 pieces or fail) and discards the unplayed remainder of a failed round. It reports a per-round summary and latches protocol and timeout errors.

---
 rtl/tetris_pkg.sv | 29 ++
 rtl/tetris_req_fifo.sv | 57 +++++
 rtl/tetris_round_scheduler.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared constants and types for the Tetris round scheduler.
// Board geometry, piece encoding and scheduler state encoding.
package tetris_pkg;

    localparam int ROUND_LEN    = 16;
    localparam int BOARD_WIDTH  = 6;
    localparam int BOARD_HEIGHT = 12;

    typedef logic [2:0] tetromino_t;

    typedef struct packed {
        tetromino_t kind;
        logic [2:0] pos;
    } piece_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } sched_state_t;

    function automatic logic on_board(logic [2:0] col, int row);
        return (int'(col) < BOARD_WIDTH) && (row < BOARD_HEIGHT);
    endfunction

endpackage

// File: rtl/tetris_req_fifo.sv
// Small synchronous request FIFO holding pending pieces.
// Callers guarantee no push when full and no pop when empty.
module tetris_req_fifo
    import tetris_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = piece_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);

endmodule

// File: rtl/tetris_round_scheduler.sv
// Issues buffered piece requests to the Tetris engine one at a time,
// tracks round boundaries, drains failed rounds and latches errors.
module tetris_round_scheduler #(
    parameter int DEPTH     = 4,
    parameter int ROUND_LEN = tetris_pkg::ROUND_LEN,
    parameter int TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_tetromino,
    input  logic [2:0] req_position,
    output logic       eng_in_valid,
    output logic [2:0] eng_tetrominoes,
    output logic [2:0] eng_position,
    input  logic       eng_score_valid,
    input  logic       eng_fail,
    input  logic [3:0] eng_score,
    output logic       round_done,
    output logic [3:0] round_score,
    output logic       round_fail,
    output logic [4:0] round_pieces,
    output logic [7:0] round_id,
    output logic       err
);

    import tetris_pkg::*;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [4:0] RL = 5'(ROUND_LEN);

    sched_state_t state;
    piece_t       cur;
    piece_t       fifo_head;
    piece_t       req_piece;
    logic [TW-1:0] timer;
    logic [4:0]   played;
    logic [4:0]   played_n;
    logic [4:0]   drop;
    logic [3:0]   score_q;
    logic         run;
    logic         spurious;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    assign req_piece = '{kind: req_tetromino, pos: req_position};
    assign spurious  = eng_score_valid && (state != S_WAIT);
    assign played_n  = played + 5'd1;

    // run keeps req_ready low while reset is held and for one cycle after
    assign req_ready = run && !fifo_full && (state != S_ERR);
    assign fifo_push = req_valid && req_ready;
    assign fifo_pop  = !spurious &&
                       (((state == S_IDLE) && !fifo_empty) ||
                        ((state == S_DRAIN) && (drop != '0) &&
                         (fifo_count != '0)));

    assign eng_in_valid    = (state == S_ISSUE);
    assign eng_tetrominoes = eng_in_valid ? cur.kind : '0;
    assign eng_position    = eng_in_valid ? cur.pos : '0;
    assign round_done      = (state == S_DONE);
    assign err             = (state == S_ERR);

    tetris_req_fifo #(
        .DEPTH (DEPTH),
        .T     (piece_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (req_piece),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cur          <= '0;
            timer        <= '0;
            played       <= '0;
            drop         <= '0;
            score_q      <= '0;
            run          <= 1'b0;
            round_score  <= '0;
            round_fail   <= 1'b0;
            round_pieces <= '0;
            round_id     <= '0;
        end else begin
            run <= 1'b1;
            if (spurious) begin
                state <= S_ERR;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (!fifo_empty) begin
                            cur   <= fifo_head;
                            state <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        timer <= '0;
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (eng_score_valid) begin
                            played  <= played_n;
                            score_q <= eng_score;
                            if (eng_fail && (played_n < RL)) begin
                                drop  <= RL - played_n;
                                state <= S_DRAIN;
                            end else if (eng_fail || (played_n == RL)) begin
                                round_score  <= eng_score;
                                round_fail   <= eng_fail;
                                round_pieces <= played_n;
                                round_id     <= round_id + 8'd1;
                                state        <= S_DONE;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else if (timer == T_LAST) begin
                            state <= S_ERR;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        // only reached from a failed result, so fail is 1
                        if (drop == '0) begin
                            round_score  <= score_q;
                            round_fail   <= 1'b1;
                            round_pieces <= played;
                            round_id     <= round_id + 8'd1;
                            state        <= S_DONE;
                        end else if (fifo_count != '0) begin
                            drop <= drop - 5'd1;
                        end
                    end
                    S_DONE: begin
                        played <= '0;
                        state  <= S_IDLE;
                    end
                    S_ERR: ;
                    default: state <= S_ERR;
                endcase
            end
        end
    end

endmodule
